// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and line-level constants (transmitter and receiver)
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;
    localparam logic UART_STOP  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with a one-cycle bit_end strobe and restart input
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter (start, LSB-first data, STOP_BITS stop bits)
// Optional parity bit after D7 when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    uart_state_e               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      bit_end;
    logic                      clr;
`ifdef UART_TX_PARITY_EN
    logic                      par_q, par_d;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    shift_d = din;
                    state_d = START;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^din) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // bit_cnt is reused to count stop bits
                if (bit_end) begin
                    if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state so they line up with the state they describe
    always_comb begin
        tx_d = UART_IDLE;
        case (state_d)
            START:   tx_d = UART_START;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            STOP:    tx_d = UART_STOP;
            default: tx_d = UART_IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && (state_d == IDLE);
    end

    assign clr = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= UART_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a per-cycle frame queue model
module tb_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
    localparam logic [11:0] A5_A_LIT = 12'b010100101010;
    localparam logic [11:0] A5_B_LIT = 12'b111101001010;
    localparam int DONE_A = 45;
    localparam int DONE_B = 49;
`else
    localparam int PAR_BITS = 0;
    localparam logic [11:0] A5_A_LIT = 12'b001101001010;
    localparam logic [11:0] A5_B_LIT = 12'b011101001010;
    localparam int DONE_A = 41;
    localparam int DONE_B = 45;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       tx_valid;
    logic       ready_a, tx_a, busy_a, done_a;
    logic       ready_b, tx_b, busy_b, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .din(din), .tx_valid(tx_valid),
        .tx_ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst(rst), .din(din), .tx_valid(tx_valid),
        .tx_ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame bit idx: 0 = start, 1..8 = data LSB first, optional parity, then stop bits
    function automatic logic frame_bit(input logic [7:0] d, input bit odd, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (PAR_BITS == 1 && idx == 9) return odd ? ~^d : ^d;
        return 1'b1;
    endfunction

    function automatic int frame_len(input int stop_bits);
        return 9 + PAR_BITS + stop_bits;
    endfunction

    // Model: each queue holds the expected line level for every remaining busy cycle
    logic qa[$];
    logic qb[$];
    logic done_ea = 1'b0;
    logic done_eb = 1'b0;
    bit   armed   = 1'b0;

    always @(posedge clk) begin
        bit empty_a;
        bit empty_b;
        if (rst) begin
            qa.delete();
            qb.delete();
            done_ea = 1'b0;
            done_eb = 1'b0;
            armed   = 1'b1;
        end else begin
            empty_a = (qa.size() == 0);
            empty_b = (qb.size() == 0);
            done_ea = 1'b0;
            done_eb = 1'b0;
            if (!empty_a) begin
                qa.delete(0);
                done_ea = (qa.size() == 0);
            end
            if (!empty_b) begin
                qb.delete(0);
                done_eb = (qb.size() == 0);
            end
            if (empty_a && tx_valid)
                for (int b = 0; b < frame_len(1); b++)
                    for (int c = 0; c < CPB; c++) qa.push_back(frame_bit(din, 1'b0, b));
            if (empty_b && tx_valid)
                for (int b = 0; b < frame_len(2); b++)
                    for (int c = 0; c < CPB; c++) qb.push_back(frame_bit(din, 1'b1, b));
        end
    end

    always @(negedge clk) begin
        logic ea, eb;
        if (armed) begin
            ea = 1'b1;
            eb = 1'b1;
            if (qa.size() != 0) ea = qa[0];
            if (qb.size() != 0) eb = qb[0];
            chk("a_tx",    tx_a,    ea);
            chk("a_busy",  busy_a,  qa.size() != 0);
            chk("a_ready", ready_a, qa.size() == 0);
            chk("a_done",  done_a,  done_ea);
            chk("b_tx",    tx_b,    eb);
            chk("b_busy",  busy_b,  qb.size() != 0);
            chk("b_ready", ready_b, qb.size() == 0);
            chk("b_done",  done_b,  done_eb);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 200; k++) begin
            if (ready_a && ready_b) break;
            tick();
        end
        chk("wait_ready", ready_a & ready_b, 1'b1);
    endtask

    logic [11:0] fr_a, fr_b;
    logic sa_tx[1:50], sa_done[1:50], sa_busy[1:50];
    logic sb_tx[1:50], sb_done[1:50];

    initial begin
        int ph, idle_cnt, ones, dcnt;
        fr_a     = A5_A_LIT;
        fr_b     = A5_B_LIT;
        rst      = 1'b1;
        tx_valid = 1'b0;
        din      = 8'h00;

        // Reset and idle line
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", tx_a, 1'b1);
        chk("rst_ready", ready_a, 1'b1);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            chk("idle_tx", tx_a, 1'b1);
        end

        // Single 0xA5 frame against hand-derived waveforms
        wait_ready();
        din = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            sa_tx[i] = tx_a; sa_done[i] = done_a; sa_busy[i] = busy_a;
            sb_tx[i] = tx_b; sb_done[i] = done_b;
            tick();
        end
        for (int i = 1; i < DONE_A; i++) begin
            chk("a5_a_tx", sa_tx[i], fr_a[(i-1)/CPB]);
            chk("a5_a_busy", sa_busy[i], 1'b1);
            chk("a5_a_nodone", sa_done[i], 1'b0);
        end
        chk("a5_a_done", sa_done[DONE_A], 1'b1);
        chk("a5_a_busy_end", sa_busy[DONE_A], 1'b0);
        chk("a5_a_done_once", sa_done[DONE_A+1], 1'b0);
        for (int i = 1; i < DONE_B; i++) chk("a5_b_tx", sb_tx[i], fr_b[(i-1)/CPB]);
        chk("a5_b_predone", sb_done[DONE_B-1], 1'b0);
        chk("a5_b_done", sb_done[DONE_B], 1'b1);

        // Back-to-back 0x00 then 0xFF with tx_valid held high
        wait_ready();
        din = 8'h00;
        tx_valid = 1'b1;
        tick();
        din = 8'hFF;
        ph = 0; idle_cnt = 0; ones = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            case (ph)
                0: if (!busy_a) begin ph = 1; idle_cnt = 1; end
                1: if (busy_a) begin ph = 2; ones = int'(tx_a); end else idle_cnt++;
                2: if (busy_a) ones += int'(tx_a); else ph = 3;
                default: ;
            endcase
            tick();
            if (ph >= 2) tx_valid = 1'b0;
        end
        chk_int("b2b_complete", ph, 3);
        chk_int("b2b_idle_cycles", idle_cnt, 1);
        chk_int("b2b_ones", ones, 36);

        // Input churn during a 0x3C frame
        wait_ready();
        din = 8'h3C;
        tx_valid = 1'b1;
        tick();
        dcnt = 0;
        for (int i = 1; i <= 55; i++) begin
            if (i <= 36) begin
                din = 8'($urandom);
                tx_valid = 1'($urandom);
            end else begin
                tx_valid = 1'b0;
            end
            @(negedge clk);
            if (i <= 36) chk("churn_ready", ready_a, 1'b0);
            if (i == 5 || i == 9) chk("churn_d0d1", tx_a, 1'b0);
            if (i == 13 || i == 25) chk("churn_d2d5", tx_a, 1'b1);
            dcnt += int'(done_a);
            tick();
        end
        chk_int("churn_done_pulses", dcnt, 1);

        // Reset during data bit 3, then a clean 0x55 frame
        wait_ready();
        din = 8'h96;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (17) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx", tx_a, 1'b1);
        chk("midrst_ready", ready_a, 1'b1);
        chk("midrst_done", done_a, 1'b0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            @(negedge clk);
            dcnt += int'(done_a) + int'(done_b);
        end
        chk_int("midrst_no_done", dcnt, 0);
        wait_ready();
        din = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 5) chk("f55_d0", tx_a, 1'b1);
            if (i == 9) chk("f55_d1", tx_a, 1'b0);
            tick();
        end

        // Randomised traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            din      = 8'($urandom);
            rst      = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        tx_valid = 1'b0;
        repeat (60) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter, the serial-output counterpart of the team's UART receiver. It accepts a parallel byte through a valid/ready handshake and serialises it as 8N1: one start bit (0), 8 data bits LSB first, then STOP_BITS stop bits (1). Bit timing comes from an internal clock-enable divider. The block sits between the host/byte-source logic and the board TX pin.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range >= 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only when UART_TX_PARITY_EN is defined

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
din  in  8  byte to transmit, sampled on the handshake
tx_valid  in  1  din is valid
tx_ready  out  1  high only in IDLE; handshake occurs when tx_valid & tx_ready
tx  out  1  serial line, registered, idles high
busy  out  1  high from the cycle after the handshake until the last stop-bit cycle, inclusive
done  out  1  one-cycle pulse on the first IDLE cycle after the final stop bit

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, tx=1, tx_ready=1, busy=0, done=0, bit counter=0, baud counter=0, shift register=0.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: tx=1. A handshake at edge t loads din into the shift register and moves to START. Changes to din after the handshake have no effect.
- Latency: tx=0 starting the cycle after the handshake (t+1).
- Each bit lasts exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1 and clears on every state change.
- DATA: tx=shift[0]; the register shifts right at each bit end. A 3-bit counter advances to STOP (or PARITY) after bit 7.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then the state returns to IDLE.
- For the 8N1 frame with handshake at t, the stop bit ends at t+10*CLKS_PER_BIT. At t+10*CLKS_PER_BIT+1 the block is in IDLE with done=1 and tx_ready=1.
- Back-to-back frames: a handshake in the done cycle is legal, giving exactly one idle-high cycle between frames.
- While busy=1, tx_valid is ignored and tx_ready=0; no queueing.
- Reset mid-frame: the frame is abandoned, tx=1 on the next cycle, and no done pulse is produced.
- The tx, busy and done outputs are driven from registers; no combinational path from inputs to outputs.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted after D7, lasting CLKS_PER_BIT cycles. tx = ^data when PARITY_ODD=0 (even) or ~^data when PARITY_ODD=1 (odd). Frame length is 11 bits (plus 1 with 2 stop bits); done moves out by CLKS_PER_BIT cycles accordingly.
- Undefined: no PARITY state or logic; PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg holds: the state enum (IDLE, START, DATA, PARITY, STOP), the UART_DATA_BITS=8 constant, and the line level constants UART_IDLE=1, UART_START=0, UART_STOP=1. The receiver shares this package.
- Sub-module uart_baud_gen, parameterised by CLKS_PER_BIT, inputs clk, rst, clr:
  - Outputs a one-cycle bit_end strobe when its counter reaches CLKS_PER_BIT-1.
  - clr restarts the count; uart_tx pulses it on every state change.
  - Reusable by the receiver for mid-bit sampling.

Test Plan:
1. Reset, CLKS_PER_BIT=4: hold rst 3 cycles -> tx=1, tx_ready=1, busy=0, done=0. Then tx_valid=0 for 20 cycles -> tx stays 1.
2. din=0xA5 handshake at t, CLKS_PER_BIT=4 -> tx is 0 for t+1..t+4, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop=1 for t+37..t+40. done=1 only at t+41; busy=1 for t+1..t+40.
3. Back-to-back: tx_valid held high with din=0x00 then 0xFF -> the second handshake lands in the done cycle of the first frame. Exactly 1 idle-high cycle separates the frames; the second frame shows 8 ones.
4. Mid-frame din/tx_valid churn: din toggles randomly and tx_valid pulses during the 0x3C frame -> tx_ready=0 throughout and the serialised bits equal 0,0,1,1,1,1,0,0. Only one done pulse.
5. Reset asserted during data bit 3 -> tx=1 the next cycle, no done pulse, tx_ready=1. A subsequent 0x55 frame is transmitted correctly.
6. UART_TX_PARITY_EN defined, STOP_BITS=2, din=0xA5:
   - PARITY_ODD=0 -> parity bit 0; PARITY_ODD=1 -> parity bit 1.
   - Stop high for 8 cycles; done at t+49 with CLKS_PER_BIT=4.
